des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have: clk_i  input  1  single clock; all state on rising edge.
REQ-002 SHALL have: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: start_i  input  1  request a new 16-subkey sequence; sampled on clk_i.
REQ-004 SHALL have: key_i  input  64  DES key; key_i[63] = FIPS 46-3 key bit 1; bits 8,16,...,64 (parity) ignored.
REQ-005 SHALL have: decrypt_i  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with start_i.
REQ-006 SHALL have: subkey_ready_i  input  1  consumer accepts the presented subkey.
REQ-007 SHALL have: subkey_o  output  48  round subkey; subkey_o[47] = FIPS PC-2 output bit 1, bit-aligned with the 48-bit expansion output for direct XOR.
REQ-008 SHALL have: subkey_valid_o  output  1  subkey_o holds a valid subkey.
REQ-009 SHALL have: round_o  output  5  DES round number (1..16) of the presented subkey; 0 when idle.
REQ-010 SHALL have: last_o  output  1  presented subkey is the final one of the sequence.
REQ-011 SHALL have: busy_o  output  1  sequence in progress.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, RUN.
REQ-013 In IDLE with start_i=1, SHALL load C/D (28+28 bits) = FIPS PC-1(key_i), latch decrypt_i, then go to RUN.
REQ-014 On load: encrypt SHALL store C/D rotated left by 1; decrypt SHALL store C/D unrotated (C16D16 = C0D0).
REQ-015 subkey_o SHALL be FIPS PC-2 of the registered C/D, purely combinational from registers; no other logic between register and port.
REQ-016 First subkey SHALL be valid on the cycle after start_i is accepted (latency 1 cycle).
REQ-017 In RUN, subkey_valid_o=1 and busy_o=1 continuously.
REQ-018 Handshake: a subkey transfers on a cycle with subkey_valid_o=1 and subkey_ready_i=1; with subkey_ready_i=0, subkey_o, round_o, last_o SHALL hold stable.
REQ-019 On each transfer other than the last, encrypt SHALL rotate C and D left by the FIPS shift for the next round (rounds 1..16 shifts: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
REQ-020 On each transfer other than the last, decrypt SHALL rotate C and D right by the shift of the round just presented (sequence after K16: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
REQ-021 round_o SHALL step 1->16 (encrypt) or 16->1 (decrypt) by one per transfer.
REQ-022 last_o SHALL be 1 exactly when subkey_valid_o=1 and round_o is 16 (encrypt) or 1 (decrypt).
REQ-023 On the last transfer, SHALL return to IDLE; next cycle subkey_valid_o=0, busy_o=0, round_o=0.
REQ-024 start_i in RUN (including the last-transfer cycle) SHALL be ignored; no restart or queuing.
REQ-025 key_i and decrypt_i changes during RUN SHALL not affect the sequence.
REQ-026 In IDLE, C/D SHALL retain their values; subkey_o is don't-care but stable.
REQ-027 Rotations SHALL be within each 28-bit half independently, wrapping modulo 28.

Reset
REQ-028 rst_i=1 SHALL immediately, without a clock edge, force IDLE, C/D=0, round_o=0, subkey_valid_o=0, last_o=0, busy_o=0, subkey_o=0.
REQ-029 Reset mid-sequence SHALL abort it; after release the block SHALL be in IDLE and require a new start_i.

Verification
REQ-030 Encrypt: key_i=64'h133457799BBCDFF1, decrypt_i=0, start_i pulse, subkey_ready_i=1 -> next cycle subkey_o=48'h1B02EFFC7072, round_o=1; 16th subkey 48'hCB3D8B0E17F5, round_o=16, last_o=1; then idle.
REQ-031 Decrypt, same key -> first subkey 48'hCB3D8B0E17F5 with round_o=16; last 48'h1B02EFFC7072 with round_o=1, last_o=1; all 16 equal the encrypt set reversed.
REQ-032 Backpressure: subkey_ready_i random 50% -> exactly 16 transfers, each output held stable while ready=0, sequence identical to REQ-030.
REQ-033 start_i held high throughout and key_i changed mid-RUN -> one sequence for the original key; a new sequence starts only after returning to IDLE.
REQ-034 rst_i asserted asynchronously at round 7 -> outputs zero before the next clock edge; after release no valid until new start_i.
REQ-035 Random keys vs software DES key-schedule model, both directions, 1000 keys -> all subkeys match; parity bits toggled -> identical subkeys.

Source files
------------

// File: rtl/des_key_schedule.sv
// des_key_schedule -- DES round-subkey generator.
//
// Purpose: on start_i, loads C/D = PC-1(key_i). It then presents the 16 round
// subkeys PC-2(C/D) one at a time through a valid/ready handshake, in
// K1..K16 order (encrypt) or K16..K1 order (decrypt).
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   start_i         request a new 16-subkey sequence (ignored while busy)
//   key_i[63:0]     DES key, key_i[63] = FIPS bit 1, parity bits ignored
//   decrypt_i       0: K1..K16, 1: K16..K1 (sampled with start_i)
//   subkey_ready_i  consumer accepts the presented subkey
//   subkey_o[47:0]  round subkey, subkey_o[47] = PC-2 output bit 1
//   subkey_valid_o  subkey_o is valid
//   round_o[4:0]    round number of the presented subkey, 0 when idle
//   last_o          presented subkey is the final one of the sequence
//   busy_o          sequence in progress
module des_key_schedule (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        subkey_ready_i,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    output logic [4:0]  round_o,
    output logic        last_o,
    output logic        busy_o
);

    // FIPS bit numbers (1-based, bit 1 = MSB) for each output position.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [55:0] r_cd;      // {C, D}; r_cd[55] = C bit 1
    logic        r_dec;
    logic [4:0]  r_round;

    logic [55:0] w_pc1, w_cd_load, w_cd_step;
    logic [47:0] w_pc2;
    logic        w_run, w_xfer, w_last, w_one;
    logic        w_unused_parity;

    // Parity bits (FIPS 8,16,...,64) take no part in the schedule.
    assign w_unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                               key_i[24], key_i[16], key_i[8],  key_i[0]};

    function automatic logic [27:0] rotl(input logic [27:0] h, input logic one);
        return one ? {h[26:0], h[27]} : {h[25:0], h[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] h, input logic one);
        return one ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
    endfunction

    // Rounds 1, 2, 9 and 16 use a single-bit shift; all others shift by two.
    function automatic logic one_shift(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    always_comb begin
        w_pc1 = '0;
        for (int i = 0; i < 56; i++) w_pc1[55-i] = key_i[64-PC1[i]];
    end

    always_comb begin
        w_pc2 = '0;
        for (int j = 0; j < 48; j++) w_pc2[47-j] = r_cd[56-PC2[j]];
    end

    // Encrypt preloads C1D1 so K1 is available one cycle after start;
    // decrypt starts from C16D16, which equals C0D0.
    assign w_cd_load = decrypt_i ? w_pc1
                                 : {rotl(w_pc1[55:28], 1'b1), rotl(w_pc1[27:0], 1'b1)};

    // Encrypt moves forward using the next round's shift; decrypt undoes the
    // shift of the round just presented.
    assign w_one     = r_dec ? one_shift(r_round) : one_shift(r_round + 5'd1);
    assign w_cd_step = r_dec ? {rotr(r_cd[55:28], w_one), rotr(r_cd[27:0], w_one)}
                             : {rotl(r_cd[55:28], w_one), rotl(r_cd[27:0], w_one)};

    assign w_run  = (r_state == S_RUN);
    assign w_last = w_run && (r_dec ? (r_round == 5'd1) : (r_round == 5'd16));
    assign w_xfer = w_run && subkey_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i)         w_state_nxt = S_RUN;
            S_RUN:   if (w_xfer && w_last) w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cd    <= '0;
            r_dec   <= 1'b0;
            r_round <= '0;
        end else if (!w_run) begin
            if (start_i) begin
                r_cd    <= w_cd_load;
                r_dec   <= decrypt_i;
                r_round <= decrypt_i ? 5'd16 : 5'd1;
            end
        end else if (w_xfer) begin
            if (w_last) begin
                r_round <= '0;
            end else begin
                r_cd    <= w_cd_step;
                r_round <= r_dec ? r_round - 5'd1 : r_round + 5'd1;
            end
        end
    end

    assign subkey_o       = w_pc2;
    assign subkey_valid_o = w_run;
    assign busy_o         = w_run;
    assign round_o        = r_round;
    assign last_o         = w_last;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        subkey_ready_i;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic [4:0]  round_o;
    logic        last_o;
    logic        busy_o;

    des_key_schedule dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .subkey_ready_i (subkey_ready_i),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .round_o        (round_o),
        .last_o         (last_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          rdy_pct;
        logic [47:0] first;
        logic [47:0] last;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [47:0] exp_ks [16];   // K1..K16 from the reference model
    logic [47:0] got_ks [16];   // subkeys in order of transfer
    vec_t        tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference schedule: every Cn/Dn is derived directly from C0/D0 by the
    // cumulative left shift, working on plain bit arrays.
    task automatic model(input logic [63:0] key);
        bit c0 [28];
        bit d0 [28];
        bit cd [56];
        int tot;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64-PC1[i]];
            d0[i] = key[64-PC1[28+i]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            for (int i = 0; i < 28; i++) begin
                cd[i]    = c0[(i + tot) % 28];
                cd[28+i] = d0[(i + tot) % 28];
            end
            for (int j = 0; j < 48; j++) k[47-j] = cd[PC2[j]-1];
            exp_ks[r] = k;
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Drives one full sequence and checks every presented subkey against the
    // model, stability under backpressure, round_o/last_o, and the return to
    // idle. With mess=1, start_i stays high and key_i/decrypt_i churn.
    task automatic run_seq(input logic [63:0] key, input logic dec,
                           input int rdy_pct, input bit mess);
        int          n, cyc, idx;
        bit          held;
        logic [47:0] p_key;
        logic [4:0]  p_round;
        logic        p_last;
        model(key);
        key_i          = key;
        decrypt_i      = dec;
        start_i        = 1'b1;
        subkey_ready_i = 1'b0;
        tick();
        if (!mess) start_i = 1'b0;
        n = 0; cyc = 0; held = 0;
        p_key = '0; p_round = '0; p_last = 1'b0;
        while (n < 16 && cyc < 400) begin
            if (mess) begin
                key_i     = {$urandom(), $urandom()};
                decrypt_i = 1'($urandom_range(1));
            end
            chk("valid_in_run", 64'(subkey_valid_o), 64'd1);
            chk("busy_in_run", 64'(busy_o), 64'd1);
            if (held) begin
                chk("hold_subkey", 64'(subkey_o), 64'(p_key));
                chk("hold_round", 64'(round_o), 64'(p_round));
                chk("hold_last", 64'(last_o), 64'(p_last));
            end
            subkey_ready_i = ($urandom_range(99) < rdy_pct);
            if (subkey_ready_i) begin
                idx = dec ? 15 - n : n;
                chk("subkey", 64'(subkey_o), 64'(exp_ks[idx]));
                chk("round", 64'(round_o), 64'(idx + 1));
                chk("last", 64'(last_o), 64'(n == 15));
                got_ks[n] = subkey_o;
                n++;
                held = 0;
            end else begin
                held    = 1;
                p_key   = subkey_o;
                p_round = round_o;
                p_last  = last_o;
            end
            tick();
            cyc++;
        end
        chk("transfer_count", 64'(n), 64'd16);
        subkey_ready_i = 1'b0;
        chk("idle_valid", 64'(subkey_valid_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_round", 64'(round_o), 64'd0);
        chk("idle_last", 64'(last_o), 64'd0);
    endtask

    initial begin
        logic [63:0] k2;
        logic        d2;
        logic [47:0] enc_ks [16];
        int          cyc;

        rst_i = 1'b1; start_i = 1'b0; key_i = '0; decrypt_i = 1'b0; subkey_ready_i = 1'b0;
        #2;
        chk("reset_valid", 64'(subkey_valid_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_round", 64'(round_o), 64'd0);
        chk("reset_subkey", 64'(subkey_o), 64'd0);
        chk("reset_last", 64'(last_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Known-answer table: standard key both ways, backpressure, parity toggled.
        tbl[0] = '{KEY_STD, 1'b0, 100, K1_STD, K16_STD};
        tbl[1] = '{KEY_STD, 1'b1, 100, K16_STD, K1_STD};
        tbl[2] = '{KEY_STD, 1'b0, 50, K1_STD, K16_STD};
        tbl[3] = '{KEY_STD ^ 64'h0101010101010101, 1'b0, 100, K1_STD, K16_STD};
        for (int t = 0; t < 4; t++) begin
            run_seq(tbl[t].key, tbl[t].dec, tbl[t].rdy_pct, 1'b0);
            chk($sformatf("tbl%0d_first", t), 64'(got_ks[0]), 64'(tbl[t].first));
            chk($sformatf("tbl%0d_last", t), 64'(got_ks[15]), 64'(tbl[t].last));
        end

        // Decrypt order is exactly the encrypt set reversed.
        run_seq(KEY_STD, 1'b0, 100, 1'b0);
        for (int i = 0; i < 16; i++) enc_ks[i] = got_ks[i];
        run_seq(KEY_STD, 1'b1, 70, 1'b0);
        for (int i = 0; i < 16; i++) chk("dec_reversed", 64'(got_ks[i]), 64'(enc_ks[15-i]));

        // start_i held high with key churn: one sequence for the original key,
        // then a fresh load of whatever key_i holds once idle.
        run_seq(KEY_STD, 1'b0, 60, 1'b1);
        k2 = key_i;
        d2 = decrypt_i;
        tick();
        model(k2);
        chk("restart_valid", 64'(subkey_valid_o), 64'd1);
        chk("restart_subkey", 64'(subkey_o), 64'(exp_ks[d2 ? 15 : 0]));
        chk("restart_round", 64'(round_o), d2 ? 64'd16 : 64'd1);
        start_i = 1'b0;
        subkey_ready_i = 1'b1;
        cyc = 0;
        while (subkey_valid_o && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("restart_drain", 64'(subkey_valid_o), 64'd0);
        subkey_ready_i = 1'b0;
        tick();

        // Asynchronous reset at round 7.
        key_i = KEY_STD; decrypt_i = 1'b0; start_i = 1'b1; subkey_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (6) tick();
        chk("pre_reset_round", 64'(round_o), 64'd7);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 64'(subkey_valid_o), 64'd0);
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_round", 64'(round_o), 64'd0);
        chk("async_rst_subkey", 64'(subkey_o), 64'd0);
        chk("async_rst_last", 64'(last_o), 64'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_valid", 64'(subkey_valid_o), 64'd0);
            chk("post_reset_round", 64'(round_o), 64'd0);
        end

        // Random keys, both directions, with parity bits scrambled for the
        // second pass so parity independence is exercised too.
        for (int i = 0; i < 1000; i++) begin
            k2 = {$urandom(), $urandom()};
            run_seq(k2, 1'b0, 100, 1'b0);
            run_seq(k2 ^ {8{7'b0, 1'($urandom_range(1))}}, 1'b1, 100, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
